sccb_init_ctrlmod: RTL and testbench

Power-up initialisation sequencer for the OV7670 camera. It walks an external register look-up table of 16-bit {register address, value} words and issues one SCCB write per entry through the SCCB write function module, using its iCall/oDone handshake. It supports inline delay markers, a per-write watchdog and an end-of-table marker. It sits between the camera top level and the SCCB function module, and gates the capture path through oInitDone.

---
 rtl/sccb_init_ctrlmod.sv | 168 ++++++++++++++++
 tb/tb_sccb_init_ctrlmod.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_init_ctrlmod.sv
// ============================================================================
//  Module   : sccb_init_ctrlmod
//  Purpose  : OV7670 power-up sequencer; walks a {reg, value} LUT and issues
//             one SCCB write per entry, with delay/end markers and a watchdog.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sccb_init_ctrlmod #(
    parameter logic [7:0]  LUT_SIZE       = 8'd168,
    parameter logic [23:0] PWRUP_CYCLES   = 24'd1_000_000,
    parameter logic [23:0] DELAY_CYCLES   = 24'd500_000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000,
    parameter logic [15:0] END_MARK       = 16'hFFFF,
    parameter logic [15:0] DELAY_MARK     = 16'hFFF0
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        iStart,
    output logic [7:0]  oAddr,
    input  logic [15:0] iLutData,
    output logic        oCall,
    input  logic        iDone,
    output logic [15:0] oData,
    output logic        oBusy,
    output logic        oInitDone,
    output logic        oError
);

    localparam logic [3:0] c_IDLE  = 4'd0;
    localparam logic [3:0] c_PWRUP = 4'd1;
    localparam logic [3:0] c_ADDR  = 4'd2;
    localparam logic [3:0] c_FETCH = 4'd3;
    localparam logic [3:0] c_CALL  = 4'd4;
    localparam logic [3:0] c_NEXT  = 4'd5;
    localparam logic [3:0] c_DELAY = 4'd6;
    localparam logic [3:0] c_DONE  = 4'd7;
    localparam logic [3:0] c_ERR   = 4'd8;

    localparam logic [23:0] c_PWRUP_LAST   = PWRUP_CYCLES - 24'd1;
    localparam logic [23:0] c_DELAY_LAST   = DELAY_CYCLES - 24'd1;
    localparam logic [23:0] c_TIMEOUT_LAST = TIMEOUT_CYCLES - 24'd1;
    localparam logic [7:0]  c_LAST_INDEX   = LUT_SIZE - 8'd1;

    logic [3:0]  state_q, state_d;
    logic [7:0]  index_q, index_d;
    logic [23:0] count_q, count_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        call_q, call_d;
    logic        init_done_q, init_done_d;
    logic        error_q, error_d;

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        count_d     = count_q;
        addr_d      = addr_q;
        data_d      = data_q;
        call_d      = call_q;
        init_done_d = init_done_q;
        error_d     = error_q;

        case (state_q)
            c_IDLE, c_DONE, c_ERR: begin
                if (iStart) begin
                    init_done_d = 1'b0;
                    error_d     = 1'b0;
                    index_d     = 8'd0;
                    count_d     = 24'd0;
                    state_d     = c_PWRUP;
                end
            end
            c_PWRUP: begin
                if (count_q == c_PWRUP_LAST) begin
                    count_d = 24'd0;
                    state_d = c_ADDR;
                end else begin
                    count_d = count_q + 24'd1;
                end
            end
            c_ADDR: begin
                addr_d  = index_q;
                state_d = c_FETCH;
            end
            c_FETCH: begin
                if (iLutData == END_MARK) begin
                    init_done_d = 1'b1;
                    state_d     = c_DONE;
                end else if (iLutData == DELAY_MARK) begin
                    count_d = 24'd0;
                    state_d = c_DELAY;
                end else begin
                    data_d  = iLutData;
                    call_d  = 1'b1;
                    count_d = 24'd0;
                    state_d = c_CALL;
                end
            end
            c_CALL: begin
                // A completion on the terminal-count cycle still counts as success.
                if (iDone) begin
                    call_d  = 1'b0;
                    count_d = 24'd0;
                    state_d = c_NEXT;
                end else if (count_q == c_TIMEOUT_LAST) begin
                    call_d  = 1'b0;
                    error_d = 1'b1;
                    state_d = c_ERR;
                end else begin
                    count_d = count_q + 24'd1;
                end
            end
            c_DELAY: begin
                if (count_q == c_DELAY_LAST) begin
                    count_d = 24'd0;
                    state_d = c_NEXT;
                end else begin
                    count_d = count_q + 24'd1;
                end
            end
            c_NEXT: begin
                if (index_q == c_LAST_INDEX) begin
                    init_done_d = 1'b1;
                    state_d     = c_DONE;
                end else begin
                    index_d = index_q + 8'd1;
                    state_d = c_ADDR;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= c_IDLE;
            index_q     <= 8'd0;
            count_q     <= 24'd0;
            addr_q      <= 8'd0;
            data_q      <= 16'd0;
            call_q      <= 1'b0;
            init_done_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            call_q      <= call_d;
            init_done_q <= init_done_d;
            error_q     <= error_d;
        end
    end

    assign oAddr     = addr_q;
    assign oData     = data_q;
    assign oCall     = call_q;
    assign oInitDone = init_done_q;
    assign oError    = error_q;
    assign oBusy     = (state_q != c_IDLE) && (state_q != c_DONE) && (state_q != c_ERR);

endmodule

`default_nettype wire

// File: tb/tb_sccb_init_ctrlmod.sv
// ============================================================================
//  Module   : tb_sccb_init_ctrlmod
//  Purpose  : Scoreboard bench for sccb_init_ctrlmod with a behavioural SCCB.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sccb_init_ctrlmod;

    localparam int T_PWRUP   = 10;
    localparam int T_DELAY   = 20;
    localparam int T_TIMEOUT = 50;
    localparam int T_LAT     = 30;
    localparam int BOUND     = 2000;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        iStart = 1'b0;
    logic        iDone = 1'b0;
    logic [7:0]  oAddr;
    logic [15:0] iLutData;
    logic [15:0] oData;
    logic        oCall, oBusy, oInitDone, oError;

    logic [15:0] lut [0:3];
    int          cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          sccb_lat = T_LAT;
    int          max_addr = 0;
    logic        call_prev = 1'b0;
    int          rise_q[$];
    int          fall_q[$];
    int          done_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];

    sccb_init_ctrlmod #(
        .LUT_SIZE       (8'd4),
        .PWRUP_CYCLES   (24'd10),
        .DELAY_CYCLES   (24'd20),
        .TIMEOUT_CYCLES (24'd50),
        .END_MARK       (16'hFFFF),
        .DELAY_MARK     (16'hFFF0)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .iStart    (iStart),
        .oAddr     (oAddr),
        .iLutData  (iLutData),
        .oCall     (oCall),
        .iDone     (iDone),
        .oData     (oData),
        .oBusy     (oBusy),
        .oInitDone (oInitDone),
        .oError    (oError)
    );

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;

    assign iLutData = (oAddr < 8'd4) ? lut[oAddr[1:0]] : 16'hDEAD;

    // SCCB stand-in: iDone is sampled by the DUT sccb_lat edges after oCall rises.
    initial begin : sccb_model
        int rise;
        rise = 0;
        forever begin
            @(negedge CLOCK);
            if (oBusy && int'(oAddr) > max_addr) max_addr = int'(oAddr);
            iDone = 1'b0;
            if (oCall && !call_prev) begin
                rise = cyc;
                rise_q.push_back(cyc);
                obs_q.push_back(oData);
            end
            if (!oCall && call_prev) fall_q.push_back(cyc);
            if (oCall && sccb_lat > 0 && (cyc - rise) == sccb_lat - 1) begin
                iDone = 1'b1;
                done_q.push_back(cyc + 1);
            end
            call_prev = oCall;
        end
    end

    task automatic run_start(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3,
                             input int lat, output int t);
        logic [15:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        @(negedge CLOCK);
        for (int i = 0; i < 4; i++) lut[i] = w[i];
        rise_q.delete(); fall_q.delete(); done_q.delete();
        exp_q.delete(); obs_q.delete();
        max_addr = 0;
        sccb_lat = lat;
        for (int i = 0; i < 4; i++) begin
            if (w[i] == 16'hFFFF) break;
            if (w[i] != 16'hFFF0) exp_q.push_back(w[i]);
        end
        @(negedge CLOCK);
        iStart = 1'b1;
        t = cyc;
        @(negedge CLOCK);
        iStart = 1'b0;
    endtask

    task automatic wait_idle(output bit timed_out);
        int n;
        n = 0;
        while (oBusy && n < BOUND) begin
            @(negedge CLOCK);
            n++;
        end
        timed_out = oBusy;
    endtask

    task automatic test_reset;
        RESET = 1'b0;
        repeat (3) @(negedge CLOCK);
        total_cnt++;
        if ({oAddr, oData, oCall, oBusy, oInitDone, oError} !== 30'd0)
            $display("FAIL reset_outputs: got %h want 0", {oAddr, oData, oCall, oBusy, oInitDone, oError});
        else pass_cnt++;
        RESET = 1'b1;
        repeat (3) @(negedge CLOCK);
        total_cnt++;
        if (oBusy !== 1'b0) $display("FAIL reset_idle: busy got %b want 0", oBusy);
        else pass_cnt++;
    endtask

    task automatic test_basic;
        int t; bit to; logic [15:0] e, o;
        run_start(16'h1280, 16'h1100, 16'h3A04, 16'hFFFF, T_LAT, t);
        total_cnt++;
        if (oBusy !== 1'b1) $display("FAIL basic_busy: got %b want 1", oBusy);
        else pass_cnt++;
        wait_idle(to);
        total_cnt++;
        if (to) $display("FAIL basic_timeout: still busy after %0d cycles want idle", BOUND);
        else pass_cnt++;
        total_cnt++;
        if (rise_q.size() !== 3) $display("FAIL basic_calls: got %0d want 3", rise_q.size());
        else pass_cnt++;
        if (rise_q.size() >= 2 && done_q.size() >= 1) begin
            total_cnt++;
            if (rise_q[0] - t !== T_PWRUP + 3)
                $display("FAIL basic_first_call: got %0d want %0d", rise_q[0] - t, T_PWRUP + 3);
            else pass_cnt++;
            total_cnt++;
            if (rise_q[1] - done_q[0] !== 3)
                $display("FAIL basic_overhead: got %0d want 3", rise_q[1] - done_q[0]);
            else pass_cnt++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
            total_cnt++;
            if (o !== e) $display("FAIL basic_data: got %h want %h", o, e);
            else pass_cnt++;
        end
        total_cnt++;
        if ({oInitDone, oBusy, oError} !== 3'b100)
            $display("FAIL basic_status: got done/busy/err %b want 100", {oInitDone, oBusy, oError});
        else pass_cnt++;
    endtask

    task automatic test_delay;
        int t; bit to; logic [15:0] e, o;
        run_start(16'h1280, 16'hFFF0, 16'h1100, 16'hFFFF, T_LAT, t);
        wait_idle(to);
        total_cnt++;
        if (to || rise_q.size() !== 2)
            $display("FAIL delay_calls: got %0d (timeout %0b) want 2", rise_q.size(), to);
        else pass_cnt++;
        if (rise_q.size() >= 2 && done_q.size() >= 1) begin
            // NEXT/ADDR/FETCH for the marker, the pause, then NEXT/ADDR/FETCH again
            total_cnt++;
            if (rise_q[1] - done_q[0] !== T_DELAY + 6)
                $display("FAIL delay_gap: got %0d want %0d", rise_q[1] - done_q[0], T_DELAY + 6);
            else pass_cnt++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
            total_cnt++;
            if (o !== e) $display("FAIL delay_data: got %h want %h", o, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_no_end_mark;
        int t; bit to; logic [15:0] e, o;
        run_start(16'h0101, 16'h0202, 16'h0303, 16'h0404, T_LAT, t);
        wait_idle(to);
        total_cnt++;
        if (to || rise_q.size() !== 4)
            $display("FAIL noend_calls: got %0d (timeout %0b) want 4", rise_q.size(), to);
        else pass_cnt++;
        total_cnt++;
        if (max_addr !== 3) $display("FAIL noend_max_addr: got %0d want 3", max_addr);
        else pass_cnt++;
        total_cnt++;
        if ({oInitDone, oError} !== 2'b10)
            $display("FAIL noend_status: got done/err %b want 10", {oInitDone, oError});
        else pass_cnt++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
            total_cnt++;
            if (o !== e) $display("FAIL noend_data: got %h want %h", o, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_timeout;
        int t; bit to; logic [15:0] e, o;
        run_start(16'h1280, 16'h1100, 16'h3A04, 16'hFFFF, 0, t);
        wait_idle(to);
        total_cnt++;
        if ({oError, oInitDone, oCall} !== 3'b100)
            $display("FAIL timeout_status: got err/done/call %b want 100", {oError, oInitDone, oCall});
        else pass_cnt++;
        if (rise_q.size() >= 1 && fall_q.size() >= 1) begin
            total_cnt++;
            if (fall_q[0] - rise_q[0] !== T_TIMEOUT)
                $display("FAIL timeout_len: got %0d want %0d", fall_q[0] - rise_q[0], T_TIMEOUT);
            else pass_cnt++;
        end
        run_start(16'h1280, 16'h1100, 16'h3A04, 16'hFFFF, T_LAT, t);
        total_cnt++;
        if ({oError, oBusy} !== 2'b01)
            $display("FAIL restart_clear: got err/busy %b want 01", {oError, oBusy});
        else pass_cnt++;
        wait_idle(to);
        total_cnt++;
        if (to || rise_q.size() !== 3 || oInitDone !== 1'b1)
            $display("FAIL restart_done: got calls %0d done %b want 3 1", rise_q.size(), oInitDone);
        else pass_cnt++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
            total_cnt++;
            if (o !== e) $display("FAIL restart_data: got %h want %h", o, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_start_during_call;
        int t, n; bit to; logic [15:0] e, o;
        run_start(16'h1280, 16'h1100, 16'h3A04, 16'hFFFF, T_LAT, t);
        n = 0;
        while (rise_q.size() == 0 && n < BOUND) begin @(negedge CLOCK); n++; end
        repeat (5) @(negedge CLOCK);
        iStart = 1'b1;
        @(negedge CLOCK);
        iStart = 1'b0;
        wait_idle(to);
        total_cnt++;
        if (to || rise_q.size() !== 3 || oInitDone !== 1'b1)
            $display("FAIL busy_start_done: got calls %0d done %b want 3 1", rise_q.size(), oInitDone);
        else pass_cnt++;
        if (rise_q.size() >= 2 && done_q.size() >= 1) begin
            total_cnt++;
            if (rise_q[1] - done_q[0] !== 3)
                $display("FAIL busy_start_gap: got %0d want 3", rise_q[1] - done_q[0]);
            else pass_cnt++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
            total_cnt++;
            if (o !== e) $display("FAIL busy_start_data: got %h want %h", o, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_simultaneous;
        int t; bit to;
        run_start(16'h1280, 16'h1100, 16'h3A04, 16'hFFFF, T_TIMEOUT, t);
        wait_idle(to);
        total_cnt++;
        if (to || {oError, oInitDone} !== 2'b01 || rise_q.size() !== 3)
            $display("FAIL simul_status: got err/done %b calls %0d want 01 3", {oError, oInitDone}, rise_q.size());
        else pass_cnt++;
        if (rise_q.size() >= 1 && fall_q.size() >= 1) begin
            total_cnt++;
            if (fall_q[0] - rise_q[0] !== T_TIMEOUT)
                $display("FAIL simul_len: got %0d want %0d", fall_q[0] - rise_q[0], T_TIMEOUT);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_call;
        int t, n;
        run_start(16'h1280, 16'h1100, 16'h3A04, 16'hFFFF, T_LAT, t);
        n = 0;
        while (rise_q.size() == 0 && n < BOUND) begin @(negedge CLOCK); n++; end
        repeat (3) @(negedge CLOCK);
        total_cnt++;
        if (oCall !== 1'b1) $display("FAIL midreset_precall: got %b want 1", oCall);
        else pass_cnt++;
        #2 RESET = 1'b0;
        #1;
        total_cnt++;
        if ({oAddr, oData, oCall, oBusy, oInitDone, oError} !== 30'd0)
            $display("FAIL midreset_outputs: got %h want 0", {oAddr, oData, oCall, oBusy, oInitDone, oError});
        else pass_cnt++;
        @(negedge CLOCK);
        RESET = 1'b1;
        repeat (3) @(negedge CLOCK);
        total_cnt++;
        if ({oBusy, oCall} !== 2'b00) $display("FAIL midreset_idle: got busy/call %b want 00", {oBusy, oCall});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delay();
        test_no_end_mark();
        test_timeout();
        test_start_during_call();
        test_simultaneous();
        test_reset_mid_call();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
